// File: rtl/alu_result_checker.sv
// ============================================================================
//  Module      : alu_result_checker
//  Description : Recomputes golden ALU result/flags for each sampled beat and
//                keeps saturating pass/fail counters plus a first-fail capture.
//                Optional macro ALU_CHK_STOP_ON_ERR_EN adds a HALT-on-fail state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_checker #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] result,
    input  logic              zero,
    input  logic              overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_res,
    output logic              chk_valid,
    output logic              chk_fail
);

    localparam int         c_MSB    = DATA_W - 1;
    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef ALU_CHK_STOP_ON_ERR_EN
        , S_HALT = 2'd2
`endif
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic [DATA_W-1:0] w_gold;
    logic              w_govf;
    logic              w_illegal;
    logic              w_accept;
    logic              w_s1_fail;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_res;
    logic              r_s1_zero;
    logic              r_s1_ovf;
    logic [DATA_W-1:0] r_s1_gold;
    logic              r_s1_gzero;
    logic              r_s1_govf;
    logic              r_s1_illegal;
    logic [CNT_W-1:0]  r_s1_idx;
    logic [CNT_W-1:0]  r_beat_idx;

    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;
    logic              r_err_sticky;
    logic [CNT_W-1:0]  r_ff_idx;
    logic [DATA_W-1:0] r_ff_res;
    logic              r_chk_valid;
    logic              r_chk_fail;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    // start takes priority: a beat presented in the start cycle is dropped
    assign w_accept = in_valid && in_ready && !start;

    assign w_sum     = a_in + b_in;
    assign w_diff    = a_in - b_in;
    assign w_add_ovf = (a_in[c_MSB] == b_in[c_MSB]) && (w_sum[c_MSB]  != a_in[c_MSB]);
    assign w_sub_ovf = (a_in[c_MSB] != b_in[c_MSB]) && (w_diff[c_MSB] != a_in[c_MSB]);

    always_comb begin
        w_gold    = '0;
        w_govf    = 1'b0;
        w_illegal = 1'b0;
        case (op)
            c_OP_AND: w_gold = a_in & b_in;
            c_OP_OR:  w_gold = a_in | b_in;
            c_OP_ADD: begin
                w_gold = w_sum;
                w_govf = w_add_ovf;
            end
            c_OP_SUB: begin
                w_gold = w_diff;
                w_govf = w_sub_ovf;
            end
            // signed less-than taken from the true sign of a-b
            c_OP_SLT: w_gold = {{(DATA_W-1){1'b0}}, w_diff[c_MSB] ^ w_sub_ovf};
            default:  w_illegal = 1'b1;
        endcase
    end

    assign w_s1_fail = r_s1_illegal || (r_s1_res != r_s1_gold) ||
                       (r_s1_zero != r_s1_gzero) || (r_s1_ovf != r_s1_govf);

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_RUN;
        end
`ifdef ALU_CHK_STOP_ON_ERR_EN
        else if ((r_state == S_RUN) && r_s1_valid && w_s1_fail) begin
            w_state_nxt = S_HALT;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_res     <= '0;
            r_s1_zero    <= 1'b0;
            r_s1_ovf     <= 1'b0;
            r_s1_gold    <= '0;
            r_s1_gzero   <= 1'b0;
            r_s1_govf    <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_idx     <= '0;
            r_beat_idx   <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_err_sticky <= 1'b0;
            r_ff_idx     <= '0;
            r_ff_res     <= '0;
            r_chk_valid  <= 1'b0;
            r_chk_fail   <= 1'b0;
        end else if (start) begin
            r_s1_valid   <= 1'b0;
            r_beat_idx   <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_err_sticky <= 1'b0;
            r_ff_idx     <= '0;
            r_ff_res     <= '0;
            r_chk_valid  <= 1'b0;
            r_chk_fail   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_res     <= result;
                r_s1_zero    <= zero;
                r_s1_ovf     <= overflow;
                r_s1_gold    <= w_gold;
                r_s1_gzero   <= (w_gold == '0);
                r_s1_govf    <= w_govf;
                r_s1_illegal <= w_illegal;
                r_s1_idx     <= r_beat_idx;
                r_beat_idx   <= f_sat_inc(r_beat_idx);
            end

            r_chk_valid <= r_s1_valid;
            r_chk_fail  <= r_s1_valid && w_s1_fail;
            if (r_s1_valid) begin
                if (w_s1_fail) begin
                    r_fail_cnt <= f_sat_inc(r_fail_cnt);
                    if (!r_err_sticky) begin
                        r_err_sticky <= 1'b1;
                        r_ff_idx     <= r_s1_idx;
                        r_ff_res     <= r_s1_res;
                    end
                end else begin
                    r_pass_cnt <= f_sat_inc(r_pass_cnt);
                end
            end
        end
    end

    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign err_sticky     = r_err_sticky;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_res = r_ff_res;
    assign chk_valid      = r_chk_valid;
    assign chk_fail       = r_chk_fail;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_checker.sv
// ============================================================================
//  Module      : tb_alu_result_checker
//  Description : Scoreboard bench for alu_result_checker (16- and 4-bit counters).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [2:0]  op = '0;
    logic [31:0] result = '0;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;

    logic        in_ready, busy, err_sticky, chk_valid, chk_fail;
    logic [15:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [31:0] first_fail_res;

    logic        in_ready4, busy4, err_sticky4, chk_valid4, chk_fail4;
    logic [3:0]  pass_cnt4, fail_cnt4, first_fail_idx4;
    logic [31:0] first_fail_res4;

    int n_checks = 0;
    int n_errs   = 0;

    bit q_sb[$];
    int exp_pass, exp_fail, exp_idx;
    bit exp_err;
    logic [15:0] exp_ff_idx;
    logic [31:0] exp_ff_res;

    always #5 clk = ~clk;

    alu_result_checker #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .op(op), .result(result), .zero(zero), .overflow(overflow),
        .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
        .first_fail_idx(first_fail_idx), .first_fail_res(first_fail_res),
        .chk_valid(chk_valid), .chk_fail(chk_fail)
    );

    alu_result_checker #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .a_in(a_in), .b_in(b_in), .op(op), .result(result), .zero(zero), .overflow(overflow),
        .busy(busy4), .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4), .err_sticky(err_sticky4),
        .first_fail_idx(first_fail_idx4), .first_fail_res(first_fail_res4),
        .chk_valid(chk_valid4), .chk_fail(chk_fail4)
    );

    task automatic t_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU built on signed 64-bit arithmetic
    function automatic void f_ref(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic o,
                                  output logic ill);
        longint sa, sb, s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        o   = 1'b0;
        ill = 1'b0;
        case (f_op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'b110: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        z = (r == 32'd0);
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_valid) begin
            if (q_sb.size() == 0) t_check("spurious_chk_valid", 1, 0);
            else t_check("chk_fail", chk_fail, q_sb.pop_front());
        end
    end

    task automatic t_beat(input logic [2:0] o_op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic z, input logic o);
        logic [31:0] gr;
        logic gz, go, gi;
        bit f;
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = o_op; a_in = a; b_in = b; result = res; zero = z; overflow = o;
        f_ref(o_op, a, b, gr, gz, go, gi);
        f = gi || (gr != res) || (gz != z) || (go != o);
        q_sb.push_back(f);
        if (f) begin
            exp_fail++;
            if (!exp_err) begin
                exp_err = 1'b1;
                exp_ff_idx = 16'(exp_idx);
                exp_ff_res = res;
            end
        end else begin
            exp_pass++;
        end
        exp_idx++;
    endtask

    task automatic t_good(input logic [2:0] o_op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] gr;
        logic gz, go, gi;
        f_ref(o_op, a, b, gr, gz, go, gi);
        t_beat(o_op, a, b, gr, gz, go);
    endtask

    task automatic t_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic t_start();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q_sb.delete();
        exp_pass = 0; exp_fail = 0; exp_idx = 0; exp_err = 1'b0;
        exp_ff_idx = '0; exp_ff_res = '0;
    endtask

    task automatic t_check_counts(input string tag);
        t_check({tag, "_pass"}, pass_cnt, 16'(exp_pass));
        t_check({tag, "_fail"}, fail_cnt, 16'(exp_fail));
        t_check({tag, "_err"}, err_sticky, exp_err);
        t_check({tag, "_ffidx"}, first_fail_idx, exp_ff_idx);
        t_check({tag, "_ffres"}, first_fail_res, exp_ff_res);
        t_check({tag, "_sb_empty"}, q_sb.size(), 0);
    endtask

    task automatic t_check_zero(input string tag);
        t_check({tag, "_cnts"}, {pass_cnt, fail_cnt, first_fail_idx}, 0);
        t_check({tag, "_ffres"}, first_fail_res, 0);
        t_check({tag, "_flags"}, {in_ready, busy, err_sticky, chk_valid, chk_fail}, 0);
        t_check({tag, "_cnts4"}, {pass_cnt4, fail_cnt4, first_fail_idx4, in_ready4, busy4}, 0);
    endtask

    initial begin
        logic [2:0] legal_ops [5];
        legal_ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

        #12;
        t_check_zero("reset");
        rst_n = 1'b1;
        t_idle(2);
        t_check("idle_ready", in_ready, 0);

        // 1: single ADD, latency of two edges
        t_start();
        t_check("run_busy", {busy, in_ready}, 2'b11);
        t_beat(3'b010, 32'd1, 32'd5, 32'd6, 1'b0, 1'b0);
        t_idle(1);
        @(negedge clk);
        t_check("lat_early", chk_valid, 0);
        @(negedge clk);
        t_check("lat_due", chk_valid, 1);
        t_check("t1_pass", pass_cnt, 1);

        // 2: overflow and zero-flag corners
        t_beat(3'b010, 32'h7fffffff, 32'h40000000, 32'hbfffffff, 1'b0, 1'b1);
        t_beat(3'b110, 32'h7fffffff, 32'hcfffffff, 32'hb0000000, 1'b0, 1'b1);
        t_beat(3'b110, 32'h0000ffff, 32'h0000ffff, 32'h00000000, 1'b1, 1'b0);
        t_idle(4);
        t_check("t2_pass", pass_cnt, 4);
        t_check("t2_fail", fail_cnt, 0);

        // 3: first-fail capture; beat right behind the fail still completes
        t_start();
        t_beat(3'b111, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);
        t_beat(3'b110, 32'd5, 32'd3, 32'd3, 1'b0, 1'b0);
        t_beat(3'b010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
        t_idle(4);
        t_check_counts("t3");
        t_check("t3_ffidx_abs", first_fail_idx, 1);
        t_check("t3_ffres_abs", first_fail_res, 3);
`ifdef ALU_CHK_STOP_ON_ERR_EN
        t_check("halt_flags", {in_ready, busy}, 2'b00);
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = 3'b010; a_in = 1; b_in = 1; result = 2; zero = 0; overflow = 0;
        t_idle(4);
        t_check_counts("halt_nocount");
        t_start();
        t_check("restart_flags", {in_ready, busy, err_sticky}, 3'b110);
        t_check("restart_cnts", {pass_cnt, fail_cnt}, 0);
`else
        t_beat(3'b010, 32'd2, 32'd2, 32'd5, 1'b0, 1'b0);
        t_idle(4);
        t_check_counts("t3_extra");
        t_check("t3_keep_running", in_ready, 1);
`endif

        // 4: back-to-back random legal beats, then an illegal op
        for (int i = 0; i < 30; i++)
            t_good(legal_ops[$urandom_range(0, 4)], $urandom, (i % 7 == 0) ? 32'h80000000 : $urandom);
        t_beat(3'b011, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
        t_idle(4);
        t_check_counts("t4");

        // 6a: 4-bit counters saturate
        t_start();
        for (int i = 0; i < 20; i++) t_good(3'b010, 32'(i), 32'(3 * i));
        t_idle(4);
        t_check_counts("t6");
        t_check("sat_pass4", pass_cnt4, 4'hf);
        t_check("sat_fail4", {fail_cnt4, err_sticky4}, 0);

        // 6b: async reset mid-stream
        t_start();
        t_good(3'b000, 32'hf0f0f0f0, 32'h0ff00ff0);
        t_beat(3'b010, 32'd1, 32'd1, 32'd3, 1'b0, 1'b0);
        t_good(3'b001, 32'h1, 32'h2);
        t_idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        t_check_zero("async_rst");
        in_valid = 1'b0;
        q_sb.delete();
        #20;
        rst_n = 1'b1;
        t_idle(3);
        t_check_zero("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
